// File: rtl/aes_chain_ctrl_if.sv
// rtl/aes_chain_ctrl_if.sv - host stream and core handshake bundle for aes_chain_ctrl
//
// Purpose: groups the host input stream, the result output register handshake
// and the request/response pair towards the external aes / aesdecrypt cores.
// Ports (signals):
//   in_valid/in_data/in_ready      host block stream into the input FIFO
//   out_valid/out_data/out_ready   result register towards the host
//   core_start/core_dec/core_in    block issue towards the selected core
//   core_done/core_out             core completion pulse and result
// Modports: slave = the controller, master = host plus core pair.
interface aes_chain_ctrl_if #(
  parameter int BLK_W = 128
);
  logic             in_valid;
  logic [BLK_W-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [BLK_W-1:0] out_data;
  logic             out_ready;
  logic             core_start;
  logic             core_dec;
  logic [BLK_W-1:0] core_in;
  logic             core_done;
  logic [BLK_W-1:0] core_out;

  modport slave (
    input  in_valid, in_data, out_ready, core_done, core_out,
    output in_ready, out_valid, out_data, core_start, core_dec, core_in
  );

  modport master (
    output in_valid, in_data, out_ready, core_done, core_out,
    input  in_ready, out_valid, out_data, core_start, core_dec, core_in
  );
endinterface

// File: rtl/aes_chain_ctrl.sv
// rtl/aes_chain_ctrl.sv - ECB/CBC(/CTR) block-chaining sequencer for an aes core pair
//
// Purpose: buffers host blocks in a small FIFO, issues them one at a time to
// the encrypt or decrypt core, applies chaining and returns results through a
// valid/ready output register. Round keys are wired to the cores elsewhere.
// Optional feature macro: AES_CTR_MODE_EN (mode 2'b10 = CTR, encrypt core only).
// Ports:
//   eph1     clock, all state on posedge
//   reset_n  synchronous active-low reset
//   start    latch mode/dec/iv, clear err, begin session (IDLE only)
//   abort    flush FIFO, drop in-flight block, return to IDLE
//   mode     00 ECB, 01 CBC, 10 CTR (macro, else ECB), 11 ECB
//   dec      0 encrypt, 1 decrypt (forced 0 in CTR)
//   iv       initial chain value / CTR nonce+counter
//   bus      aes_chain_ctrl_if.slave: host in/out streams and core handshake
//   busy     session active (state != IDLE)
//   err      sticky core timeout, cleared by accepted start or reset
module aes_chain_ctrl #(
  parameter int BLK_W       = 128,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int CTR_W       = 32
) (
  input  logic             eph1,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             dec,
  input  logic [BLK_W-1:0] iv,
  aes_chain_ctrl_if.slave  bus,
  output logic             busy,
  output logic             err
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT_CYC) + 1;

  // Elaboration-time guard on the configuration space.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (TIMEOUT_CYC < 1) || (CTR_W < 1) || (CTR_W >= BLK_W)) begin : g_bad_cfg
    $error("aes_chain_ctrl: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t state;
  state_t state_nxt;

  // Input FIFO
  logic [BLK_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [BLK_W-1:0] head;

  // Session / datapath state
  logic              cbc_r;
  logic              dec_r;
  logic [BLK_W-1:0]  chain;
  logic [BLK_W-1:0]  cur;
  logic [BLK_W-1:0]  core_in_r;
  logic [BLK_W-1:0]  core_in_nxt;
  logic [BLK_W-1:0]  result;
  logic              out_valid_r;
  logic [BLK_W-1:0]  out_data_r;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_r;

`ifdef AES_CTR_MODE_EN
  logic                   ctr_r;
  logic [CTR_W-1:0]       ctr;
  logic [BLK_W-CTR_W-1:0] iv_hi;
  logic                   ctr_sel;
  assign ctr_sel = (mode == 2'b10);
`endif

  // Control strobes
  logic in_ready_int;
  logic push;
  logic pop;
  logic start_acc;
  logic issue_go;
  logic done_acc;
  logic timeout_hit;
  logic flush;

  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count == '0);
  assign head         = fifo_mem[rd_ptr];
  // Full is taken from the pre-pop count, so a full FIFO stalls even on a pop cycle.
  assign in_ready_int = (state != S_IDLE) && !fifo_full;
  assign push         = bus.in_valid && in_ready_int;

  // FSM: next state and strobes
  always_comb begin
    state_nxt   = state;
    start_acc   = 1'b0;
    issue_go    = 1'b0;
    pop         = 1'b0;
    done_acc    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          start_acc = 1'b1;
        end
      end
      S_RUN: begin
        // Issue only when the out reg is free (or freeing now), so the result
        // that comes back always has somewhere to land.
        if (!fifo_empty && (!out_valid_r || bus.out_ready)) begin
          state_nxt = S_ISSUE;
          issue_go  = 1'b1;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
        pop       = 1'b1;
      end
      S_WAIT: begin
        if (bus.core_done) begin
          state_nxt = S_RUN;
          done_acc  = 1'b1;
        end else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
          state_nxt   = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt   = S_IDLE;
      start_acc   = 1'b0;
      issue_go    = 1'b0;
      done_acc    = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  assign flush = abort || timeout_hit;

  always_ff @(posedge eph1) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge eph1) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge eph1) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.in_data;
    end
  end

  // Chaining: what goes to the core and what comes back to the host
  always_comb begin
    core_in_nxt = head;
    result      = bus.core_out;
    if (cbc_r && !dec_r) begin
      core_in_nxt = head ^ chain;
    end
    if (cbc_r && dec_r) begin
      result = bus.core_out ^ chain;
    end
`ifdef AES_CTR_MODE_EN
    if (ctr_r) begin
      core_in_nxt = {iv_hi, ctr};
      result      = bus.core_out ^ cur;
    end
`endif
  end

  always_ff @(posedge eph1) begin
    if (!reset_n) begin
      cbc_r       <= 1'b0;
      dec_r       <= 1'b0;
      chain       <= '0;
      cur         <= '0;
      core_in_r   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      wait_cnt    <= '0;
      err_r       <= 1'b0;
    end else begin
      if (start_acc) begin
        cbc_r <= (mode == 2'b01);
`ifdef AES_CTR_MODE_EN
        dec_r <= dec && !ctr_sel;
`else
        dec_r <= dec;
`endif
        chain <= iv;
        err_r <= 1'b0;
      end

      // core_in is registered one cycle ahead of core_start and held through WAIT.
      if (issue_go) begin
        core_in_r <= core_in_nxt;
      end
      if (pop) begin
        cur <= head;
      end

      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      // A pending result survives abort/timeout and drains via out_ready.
      if (done_acc) begin
        out_valid_r <= 1'b1;
        out_data_r  <= result;
        if (cbc_r) begin
          chain <= dec_r ? cur : bus.core_out;
        end
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      if (timeout_hit) begin
        err_r <= 1'b1;
      end
      if (flush) begin
        core_in_r <= '0;
        dec_r     <= 1'b0;
      end
    end
  end

`ifdef AES_CTR_MODE_EN
  // Counter wraps silently modulo 2^CTR_W.
  always_ff @(posedge eph1) begin
    if (!reset_n) begin
      ctr_r <= 1'b0;
      ctr   <= '0;
      iv_hi <= '0;
    end else begin
      if (start_acc) begin
        ctr_r <= ctr_sel;
        ctr   <= iv[CTR_W-1:0];
        iv_hi <= iv[BLK_W-1:CTR_W];
      end else if (pop && ctr_r) begin
        ctr <= ctr + CTR_W'(1);
      end
    end
  end
`endif

  assign bus.in_ready   = in_ready_int;
  assign bus.core_start = (state == S_ISSUE);
  assign bus.core_dec   = dec_r;
  assign bus.core_in    = core_in_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign busy           = (state != S_IDLE);
  assign err            = err_r;

endmodule

// File: tb/tb_aes_chain_ctrl.sv
// tb/tb_aes_chain_ctrl.sv - scoreboard bench for aes_chain_ctrl with an inverting 3-cycle core model
`timescale 1ns/1ps
module tb_aes_chain_ctrl;
  localparam int BLK_W = 128;
  typedef logic [BLK_W-1:0] blk_t;

  logic       eph1    = 1'b0;
  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic       abort   = 1'b0;
  logic [1:0] mode    = 2'b00;
  logic       dec     = 1'b0;
  blk_t       iv      = '0;
  logic       busy;
  logic       err;

  aes_chain_ctrl_if #(.BLK_W(BLK_W)) bus ();

  aes_chain_ctrl #(
    .BLK_W(BLK_W), .FIFO_DEPTH(4), .TIMEOUT_CYC(64), .CTR_W(32)
  ) dut (
    .eph1(eph1), .reset_n(reset_n), .start(start), .abort(abort),
    .mode(mode), .dec(dec), .iv(iv), .bus(bus.slave),
    .busy(busy), .err(err)
  );

  always #5 eph1 = ~eph1;

  int   tests = 0;
  int   fails = 0;
  blk_t exp_out_q [$];
  blk_t exp_cin_q [$];
  logic exp_cdec_q [$];
  bit   hang      = 1'b0;
  bit   chk_lat   = 1'b1;
  int   issue_cnt = 0;

  task automatic check(input string name, input blk_t act, input blk_t expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge eph1);
    #1;
  endtask

  task automatic expect_blk(input blk_t cin, input logic cdec, input blk_t o, input bit has_out);
    exp_cin_q.push_back(cin);
    exp_cdec_q.push_back(cdec);
    if (has_out) exp_out_q.push_back(o);
  endtask

  task automatic session(input logic [1:0] m, input logic d, input blk_t v);
    mode = m; dec = d; iv = v;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic end_session();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  task automatic push(input blk_t d);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge eph1);
      if (bus.in_ready) begin
        @(posedge eph1);
        #1;
        ok = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) check("push_accept", 0, 1);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge eph1);
      if (exp_out_q.size() == 0 && exp_cin_q.size() == 0 && !bus.out_valid) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 0, 1);
    tick(2);
  endtask

  task automatic wait_core_start();
    bit ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge eph1);
      if (bus.core_start) ok = 1'b1;
    end
    if (!ok) check("core_start_seen", 0, 1);
  endtask

  task automatic check_idle_vals(input string tag);
    check({tag, "_busy"},       busy,           0);
    check({tag, "_err"},        err,            0);
    check({tag, "_in_ready"},   bus.in_ready,   0);
    check({tag, "_out_valid"},  bus.out_valid,  0);
    check({tag, "_core_start"}, bus.core_start, 0);
    check({tag, "_core_in"},    bus.core_in,    0);
    check({tag, "_core_dec"},   bus.core_dec,   0);
  endtask

  // Core model: core_out = ~core_in, done 3 cycles after the issue cycle.
  initial begin : core_model
    blk_t cap;
    bus.core_done = 1'b0;
    bus.core_out  = '0;
    forever begin
      @(negedge eph1);
      if (bus.core_start) begin
        issue_cnt++;
        cap = bus.core_in;
        if (exp_cin_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL core_in_unexpected: got %h want none", cap);
        end else begin
          check("core_in", cap, exp_cin_q.pop_front());
          check("core_dec", bus.core_dec, exp_cdec_q.pop_front());
        end
        if (!hang) begin
          repeat (3) @(posedge eph1);
          #1;
          bus.core_done = 1'b1;
          bus.core_out  = ~cap;
          @(posedge eph1);
          #1;
          bus.core_done = 1'b0;
          if (chk_lat) check("out_valid_after_done", bus.out_valid, 1);
        end
      end
    end
  end

  // Monitor: every accepted output is compared against the scoreboard head.
  initial begin : monitor
    forever begin
      @(negedge eph1);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_out_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL out_unexpected: got %h want none", bus.out_data);
        end else begin
          check("out_data", bus.out_data, exp_out_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int   n;
    int   ic0;
    blk_t ivc;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    check_idle_vals("reset");
    check("reset_out_data", bus.out_data, 0);

    // ECB encrypt, issue latency
    session(2'b00, 1'b0, '0);
    check("run_busy", busy, 1);
    check("run_in_ready", bus.in_ready, 1);
    expect_blk(128'h1, 1'b0, ~blk_t'(128'h1), 1'b1);
    push(128'h1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge eph1);
      n++;
      if (bus.core_start) break;
    end
    check("issue_latency", n, 2);
    wait_drain();
    end_session();

    // CBC encrypt, two chained blocks
    session(2'b01, 1'b0, 128'h0F);
    expect_blk(128'h0E, 1'b0, ~blk_t'(128'h0E), 1'b1);
    expect_blk(~blk_t'(128'h0E), 1'b0, 128'h0E, 1'b1);
    push(128'h1);
    push(128'h0);
    wait_drain();
    end_session();

    // CBC decrypt
    session(2'b01, 1'b1, 128'h0F);
    expect_blk(~blk_t'(128'h0E), 1'b1, 128'h1, 1'b1);
    push(~blk_t'(128'h0E));
    wait_drain();
    end_session();

    // Backpressure: out reg held, FIFO fills, further pushes stall
    session(2'b00, 1'b0, '0);
    bus.out_ready = 1'b0;
    ic0 = issue_cnt;
    for (int b = 0; b < 6; b++) expect_blk(blk_t'(128'h10 + b), 1'b0, ~blk_t'(128'h10 + b), 1'b1);
    push(128'h10);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick(1);
      n++;
    end
    for (int b = 1; b < 5; b++) push(blk_t'(128'h10 + b));
    tick(5);
    check("full_in_ready", bus.in_ready, 0);
    check("single_issue", issue_cnt - ic0, 1);
    fork
      push(128'h15);
      begin
        tick(10);
        check("stall_in_ready", bus.in_ready, 0);
        check("out_hold", bus.out_data, ~blk_t'(128'h10));
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_issue_total", issue_cnt - ic0, 6);
    end_session();

    // Core hang: timeout after 64 WAIT cycles, FIFO flushed
    session(2'b00, 1'b0, '0);
    hang = 1'b1;
    expect_blk(128'h20, 1'b0, '0, 1'b0);
    fork
      begin
        push(128'h20);
        push(128'h21);
      end
      begin
        wait_core_start();
        n = 0;
        for (int k = 0; k < 200; k++) begin
          @(negedge eph1);
          n++;
          if (!busy) break;
        end
        check("timeout_cycles", n, 65);
      end
    join
    check("timeout_err", err, 1);
    check("timeout_in_ready", bus.in_ready, 0);
    hang = 1'b0;
    ic0 = issue_cnt;
    session(2'b00, 1'b0, '0);
    check("start_clears_err", err, 0);
    tick(6);
    check("flushed_no_issue", issue_cnt - ic0, 0);
    expect_blk(128'h22, 1'b0, ~blk_t'(128'h22), 1'b1);
    push(128'h22);
    wait_drain();
    end_session();

    // Reset in the middle of WAIT; late core_done ignored
    session(2'b01, 1'b1, 128'h0F);
    chk_lat = 1'b0;
    expect_blk(128'h33, 1'b1, '0, 1'b0);
    push(128'h33);
    wait_core_start();
    tick(1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check_idle_vals("midwait_reset");
    check("midwait_reset_out_data", bus.out_data, 0);
    tick(5);
    check("reset_late_done_ignored", bus.out_valid, 0);

    // Abort in the middle of WAIT; late core_done ignored
    session(2'b01, 1'b1, 128'h0F);
    expect_blk(128'h44, 1'b1, '0, 1'b0);
    push(128'h44);
    wait_core_start();
    tick(1);
    end_session();
    check_idle_vals("midwait_abort");
    tick(5);
    check("abort_late_done_ignored", bus.out_valid, 0);
    check("abort_still_idle", busy, 0);
    chk_lat = 1'b1;

    // Mode 10: CTR with the macro, ECB (dec honoured) without
    ivc = {96'hA5A5A5A5_5A5A5A5A_0F0F0F0F, 32'hFFFFFFFF};
    session(2'b10, 1'b1, ivc);
`ifdef AES_CTR_MODE_EN
    expect_blk(ivc, 1'b0, ~ivc ^ blk_t'(128'h1111), 1'b1);
    expect_blk({ivc[127:32], 32'h0}, 1'b0, ~{ivc[127:32], 32'h0} ^ blk_t'(128'h2222), 1'b1);
`else
    expect_blk(128'h1111, 1'b1, ~blk_t'(128'h1111), 1'b1);
    expect_blk(128'h2222, 1'b1, ~blk_t'(128'h2222), 1'b1);
`endif
    push(128'h1111);
    push(128'h2222);
    wait_drain();
    end_session();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
